spi_alu_slave: RTL and testbench
================================

Name: spi_alu_slave

Overview:
- Synthesizable SPI slave that sits directly downstream of the SPI master test driver and terminates its mosi/miso/sclk/cs link.
- Receives an 8-bit command frame {op[1:0], a[2:0], b[2:0]} LSB first and computes a 4-bit ALU result.
- Returns the result LSB first on miso in the same cs-low window.
- Runs on a fast system clock; sclk, cs and mosi are oversampled through synchronizers. The block has no sclk-domain logic.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for sclk/cs/mosi; 2 or 3 only.
- OPD_W, 3, width of each operand a and b.
- RES_W, 4, result width. Must equal OPD_W+1.

Ports:
- clk  in  1  system clock; frequency ≥ 8× sclk.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock from master, idle low.
- cs  in  1  chip select, active low.
- mosi  in  1  serial command data.
- miso  out  1  serial result data.
- busy  out  1  high while a frame is in progress.
- rx_valid  out  1  one-clk pulse when a complete 8-bit command is captured.
- rx_op  out  2  captured opcode; valid from rx_valid onward.
- rx_a  out  OPD_W  captured operand a.
- rx_b  out  OPD_W  captured operand b.
- result  out  RES_W  computed result, held until the next rx_valid.

Behaviour:
- Reset (rst_n=0, async) drives:
  - miso=0, busy=0, rx_valid=0, rx_op/rx_a/rx_b/result=0.
  - Synchronizer flops to idle values: sclk=0, cs=1, mosi=0.
  - FSM to IDLE; bit counter to 0.
- Edge detection:
  - sclk_rise/sclk_fall are one-clk pulses from the last two synchronized sclk samples.
  - cs_act = synchronized cs == 0.
- Frame format, bit i = i-th transmitted bit:
  - bits 0..2 = b[0..2]
  - bits 3..5 = a[0..2]
  - bits 6..7 = op[0..1]
- Master timing contract:
  - The master changes mosi at sclk rising edges 1..8; the slave samples mosi on sclk_fall 1..8.
  - The slave drives result[k] at sclk rising edge 9+k (k=0..3); the master samples it on the following falling edge.
- FSM states:
  - IDLE: miso=0, busy=0. On cs_act → RX, bit counter=0.
  - RX:
    - busy=1.
    - Each sclk_fall shifts synchronized mosi into shreg[7] (right-shift) and increments the counter.
    - After the 8th fall → CALC.
    - sclk_rise is ignored in RX.
  - CALC, one clk:
    - Decode shreg into rx_op/rx_a/rx_b; compute result; pulse rx_valid.
    - Load tx_shreg=result, tx counter=0 → TX.
  - TX:
    - Each sclk_rise drives miso=tx_shreg[0], then shifts tx_shreg right and increments the counter.
    - After the 4th rise → DONE. miso holds the last bit until the next rise or cs release.
  - DONE: further sclk edges are ignored; miso=0 from the next sclk_rise.
- cs release: from any state, !cs_act → IDLE and miso=0 on the next clk.
  - An incomplete RX (fewer than 8 falls) produces no rx_valid, and result is unchanged.
- ALU (package opcode):
  - ADD=0: a+b zero-extended; range 0..14, no overflow.
  - SUB=1: (a−b) mod 2^RES_W, two's complement.
  - AND=2 and OR=3: bitwise on operands, zero-extended.
- Edge-event precedence: !cs_act wins over any sclk edge in the same clk.
- Reset mid-frame fully aborts; the next cs assertion starts a fresh frame.
- Synchronizer latency is SYNC_STAGES+1 clk. The miso update must settle within half an sclk period, hence the clk ≥ 8× sclk requirement.

Decomposition:
- Package spi_alu_pkg holds:
  - typedef enum logic[1:0] opcode_e {OP_ADD, OP_SUB, OP_AND, OP_OR}
  - localparam FRAME_W=8 and RSP_W=4
  - typedef state_e {IDLE, RX, CALC, TX, DONE}
  - function alu_calc(op, a, b)
- One sub-module: spi_in_sync. It holds the SYNC_STAGES flop chains for sclk/cs/mosi plus the sclk rise/fall pulse generation, with reset values 0/1/0.

Test Plan:
- ADD a=3 b=2: frame 0x1A, mosi sequence 0,1,0,1,1,0,0,0 → rx_valid once; rx_op=0, rx_a=3, rx_b=2; miso bits on falls 9..12 = 1,0,1,0 (result=5).
- SUB a=2 b=5 → result=13 (0b1101), miso 1,0,1,1. ADD a=7 b=7 → result=14, miso 0,1,1,1.
- AND a=6 b=3 → 2. OR a=5 b=2 → 7. Run back-to-back frames with cs high for 2 sclk periods between them; results are correct and independent.
- Abort: cs released after 4 mosi bits → no rx_valid, result unchanged, miso=0. Next full frame ADD 1+1 → result=2.
- rst_n pulsed low mid-TX (after 2 result bits) → all outputs 0 immediately, FSM IDLE. Next frame OR 4|3 → 7.
- Extra sclk cycles after bit 12 with cs still low → miso=0, no second rx_valid. Repeat at SYNC_STAGES=3 with clk=8× sclk; all results still correct.

Source files
------------

// File: rtl/spi_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_alu_pkg
// Description : Shared types, frame constants and ALU helper for spi_alu_slave.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_alu_pkg;

    localparam int FRAME_W = 8;
    localparam int RSP_W   = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } opcode_e;

    typedef logic [2:0] state_e;
    localparam state_e ST_IDLE = 3'd0;
    localparam state_e ST_RX   = 3'd1;
    localparam state_e ST_CALC = 3'd2;
    localparam state_e ST_TX   = 3'd3;
    localparam state_e ST_DONE = 3'd4;

    // SUB wraps naturally in RSP_W bits, giving two's complement for a < b.
    function automatic logic [RSP_W-1:0] alu_calc(
        input opcode_e    op,
        input logic [2:0] a,
        input logic [2:0] b
    );
        logic [RSP_W-1:0] w_res;
        w_res = '0;
        case (op)
            OP_ADD:  w_res = {1'b0, a} + {1'b0, b};
            OP_SUB:  w_res = {1'b0, a} - {1'b0, b};
            OP_AND:  w_res = {1'b0, a & b};
            OP_OR:   w_res = {1'b0, a | b};
            default: w_res = '0;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_alu_slave_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_in_sync
// Description : Synchronizer chains for sclk/cs/mosi plus sclk edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
)(
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic cs_act,
    output logic mosi_sync,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [SYNC_STAGES-1:0] r_sclk_ff;
    logic [SYNC_STAGES-1:0] r_cs_ff;
    logic [SYNC_STAGES-1:0] r_mosi_ff;
    logic                   r_sclk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_ff   <= '0;
            r_cs_ff     <= '1;
            r_mosi_ff   <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_ff   <= {r_sclk_ff[SYNC_STAGES-2:0], sclk};
            r_cs_ff     <= {r_cs_ff[SYNC_STAGES-2:0],   cs};
            r_mosi_ff   <= {r_mosi_ff[SYNC_STAGES-2:0], mosi};
            r_sclk_prev <= r_sclk_ff[SYNC_STAGES-1];
        end
    end

    assign cs_act    = ~r_cs_ff[SYNC_STAGES-1];
    assign mosi_sync = r_mosi_ff[SYNC_STAGES-1];
    assign sclk_rise =  r_sclk_ff[SYNC_STAGES-1] & ~r_sclk_prev;
    assign sclk_fall = ~r_sclk_ff[SYNC_STAGES-1] &  r_sclk_prev;

endmodule
`default_nettype wire

// File: rtl/spi_alu_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_alu_slave
// Description : Oversampled SPI slave: receives {op,a,b}, returns ALU result.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_alu_slave
    import spi_alu_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int OPD_W       = 3,
    parameter int RES_W       = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    output logic             busy,
    output logic             rx_valid,
    output logic [1:0]       rx_op,
    output logic [OPD_W-1:0] rx_a,
    output logic [OPD_W-1:0] rx_b,
    output logic [RES_W-1:0] result
);

    logic w_cs_act;
    logic w_mosi;
    logic w_rise;
    logic w_fall;

    spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .cs_act    (w_cs_act),
        .mosi_sync (w_mosi),
        .sclk_rise (w_rise),
        .sclk_fall (w_fall)
    );

    state_e             r_state;
    logic [3:0]         r_bit_cnt;
    logic [FRAME_W-1:0] r_shreg;
    logic [RES_W-1:0]   r_tx_shreg;
    logic [RES_W-1:0]   w_alu;

    // Frame arrives LSB first into the MSB, so after 8 shifts bit 0 sits at [0].
    always_comb begin
        w_alu = alu_calc(opcode_e'(r_shreg[FRAME_W-1 -: 2]),
                         r_shreg[2*OPD_W-1 -: OPD_W],
                         r_shreg[OPD_W-1:0]);
    end

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_tx_shreg <= '0;
            miso       <= 1'b0;
            rx_valid   <= 1'b0;
            rx_op      <= '0;
            rx_a       <= '0;
            rx_b       <= '0;
            result     <= '0;
        end else begin
            rx_valid <= 1'b0;
            // Losing chip select overrides any sclk edge seen in the same cycle.
            if (!w_cs_act) begin
                r_state <= ST_IDLE;
                miso    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        miso      <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= ST_RX;
                    end
                    ST_RX: begin
                        if (w_fall) begin
                            r_shreg   <= {w_mosi, r_shreg[FRAME_W-1:1]};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'(FRAME_W-1))
                                r_state <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        rx_op      <= r_shreg[FRAME_W-1 -: 2];
                        rx_a       <= r_shreg[2*OPD_W-1 -: OPD_W];
                        rx_b       <= r_shreg[OPD_W-1:0];
                        result     <= w_alu;
                        rx_valid   <= 1'b1;
                        r_tx_shreg <= w_alu;
                        r_bit_cnt  <= '0;
                        r_state    <= ST_TX;
                    end
                    ST_TX: begin
                        if (w_rise) begin
                            miso       <= r_tx_shreg[0];
                            r_tx_shreg <= {1'b0, r_tx_shreg[RES_W-1:1]};
                            r_bit_cnt  <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'(RES_W-1))
                                r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (w_rise)
                            miso <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        miso    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_alu_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_alu_slave
// Description : Scoreboard bench driving two slaves (2- and 3-stage sync) in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_alu_slave;

    typedef struct {
        logic [1:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic cs = 1'b1;
    logic mosi = 1'b0;

    logic       miso2, busy2, rx_valid2;
    logic [1:0] rx_op2;
    logic [2:0] rx_a2, rx_b2;
    logic [3:0] result2;
    logic       miso3, busy3, rx_valid3;
    logic [1:0] rx_op3;
    logic [2:0] rx_a3, rx_b3;
    logic [3:0] result3;

    exp_t q2[$];
    exp_t q3[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    spi_alu_slave #(.SYNC_STAGES(2), .OPD_W(3), .RES_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso2), .busy(busy2), .rx_valid(rx_valid2), .rx_op(rx_op2),
        .rx_a(rx_a2), .rx_b(rx_b2), .result(result2)
    );

    spi_alu_slave #(.SYNC_STAGES(3), .OPD_W(3), .RES_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso3), .busy(busy3), .rx_valid(rx_valid3), .rx_op(rx_op3),
        .rx_a(rx_a3), .rx_b(rx_b3), .result(result3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("s2 unexpected rx_valid", 1, 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("s2 rx_op",  32'(rx_op2),  32'(e.op));
                check("s2 rx_a",   32'(rx_a2),   32'(e.a));
                check("s2 rx_b",   32'(rx_b2),   32'(e.b));
                check("s2 result", 32'(result2), 32'(e.res));
            end
        end
    end

    always @(negedge clk) begin
        if (rx_valid3 === 1'b1) begin
            if (q3.size() == 0) begin
                check("s3 unexpected rx_valid", 1, 0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("s3 rx_op",  32'(rx_op3),  32'(e.op));
                check("s3 rx_a",   32'(rx_a3),   32'(e.a));
                check("s3 rx_b",   32'(rx_b3),   32'(e.b));
                check("s3 result", 32'(result3), 32'(e.res));
            end
        end
    end

    task automatic check_idle(input string tag, input logic [3:0] exp_res);
        check({tag, " s2 miso"},   32'(miso2),   0);
        check({tag, " s2 busy"},   32'(busy2),   0);
        check({tag, " s2 result"}, 32'(result2), 32'(exp_res));
        check({tag, " s3 miso"},   32'(miso3),   0);
        check({tag, " s3 busy"},   32'(busy3),   0);
        check({tag, " s3 result"}, 32'(result3), 32'(exp_res));
    endtask

    // sclk period is 8 clk; edges land on clk negedges, miso sampled just before each fall.
    task automatic run_frame(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                             input logic [3:0] res, input int ncyc, input int rst_at);
        logic [7:0] fr;
        logic [3:0] nib2, nib3;
        bit         aborted;
        exp_t       e;
        fr = {op, a, b};
        nib2 = '0;
        nib3 = '0;
        aborted = 1'b0;
        e.op = op; e.a = a; e.b = b; e.res = res;
        if (ncyc >= 8) begin
            q2.push_back(e);
            q3.push_back(e);
        end
        @(negedge clk) cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 1; i <= ncyc; i++) begin
            sclk = 1'b1;
            mosi = (i <= 8) ? fr[i-1] : 1'b0;
            repeat (4) @(negedge clk);
            if (i >= 9 && i <= 12) begin
                nib2[i-9] = miso2;
                nib3[i-9] = miso3;
            end
            if (i >= 13) begin
                check("done s2 miso", 32'(miso2), 0);
                check("done s3 miso", 32'(miso3), 0);
            end
            sclk = 1'b0;
            repeat (4) @(negedge clk);
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst s2 miso",   32'(miso2),   0);
                check("rst s2 busy",   32'(busy2),   0);
                check("rst s2 result", 32'(result2), 0);
                check("rst s2 rx_op",  32'(rx_op2),  0);
                check("rst s3 miso",   32'(miso3),   0);
                check("rst s3 result", 32'(result3), 0);
                check("rst s3 rx_a",   32'(rx_a3),   0);
                @(negedge clk) cs = 1'b1;
                repeat (4) @(negedge clk);
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted && ncyc >= 12) begin
            check("s2 miso nibble", 32'(nib2), 32'(res));
            check("s3 miso nibble", 32'(nib3), 32'(res));
        end
        mosi = 1'b0;
        @(negedge clk) cs = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check_idle("reset-held", 4'd0);
        check("reset s2 rx_valid", 32'(rx_valid2), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_idle("post-reset", 4'd0);

        run_frame(2'd0, 3'd3, 3'd2, 4'd5,  12, 0);   // ADD 3+2, frame 0x1A
        run_frame(2'd1, 3'd2, 3'd5, 4'd13, 12, 0);   // SUB 2-5
        run_frame(2'd0, 3'd7, 3'd7, 4'd14, 12, 0);   // ADD 7+7
        run_frame(2'd2, 3'd6, 3'd3, 4'd2,  12, 0);   // AND 6&3
        run_frame(2'd3, 3'd5, 3'd2, 4'd7,  12, 0);   // OR 5|2
        check_idle("after OR", 4'd7);

        run_frame(2'd0, 3'd6, 3'd6, 4'd12, 4, 0);    // aborted after 4 bits
        check_idle("abort", 4'd7);

        run_frame(2'd0, 3'd1, 3'd1, 4'd2,  12, 0);   // ADD 1+1
        check_idle("after ADD", 4'd2);

        run_frame(2'd2, 3'd7, 3'd5, 4'd5,  12, 10);  // reset after 2 result bits
        check_idle("after reset", 4'd0);

        run_frame(2'd3, 3'd4, 3'd3, 4'd7,  12, 0);   // OR 4|3
        run_frame(2'd1, 3'd6, 3'd1, 4'd5,  14, 0);   // extra sclk cycles
        check_idle("after extra", 4'd5);

        check("s2 pending rx_valid", 32'(q2.size()), 0);
        check("s3 pending rx_valid", 32'(q3.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
